// File: rtl/axi_display_regs.sv
// axi_display_regs: AXI4-Lite slave register file for the display controller.
// Holds CTRL, FB_BASE, SCRATCH and TIMING, reports STATUS (enable + frame
// counter) and a sticky, maskable frame-done interrupt in IRQ_STAT.
// Build macro AXI_DISP_SHADOW_EN: when defined, the side outputs come from
// shadow copies that reload on frame_done; readback always shows live values.
`timescale 1ns/1ps
module axi_display_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    input  logic                              frame_done,
    output logic                              disp_enable,
    output logic [31:0]                       fb_base,
    output logic [15:0]                       h_active,
    output logic [15:0]                       v_active,
    output logic                              irq
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Word indices of the register map (byte address bits [4:2]).
    localparam logic [2:0] IDX_CTRL     = 3'd0;
    localparam logic [2:0] IDX_FB_BASE  = 3'd1;
    localparam logic [2:0] IDX_SCRATCH  = 3'd2;
    localparam logic [2:0] IDX_TIMING   = 3'd3;
    localparam logic [2:0] IDX_STATUS   = 3'd4;
    localparam logic [2:0] IDX_IRQ_STAT = 3'd5;

    // Write channel state
    logic        awready_q, awready_d;
    logic        wready_q,  wready_d;
    logic        aw_held_q, aw_held_d;
    logic        w_held_q,  w_held_d;
    logic [2:0]  awidx_q,   awidx_d;
    logic [31:0] wdata_q,   wdata_d;
    logic [3:0]  wstrb_q,   wstrb_d;
    logic        bvalid_q,  bvalid_d;
    logic [1:0]  bresp_q,   bresp_d;

    // Read channel state
    logic        arready_q, arready_d;
    logic        rvalid_q,  rvalid_d;
    logic [31:0] rdata_q,   rdata_d;
    logic [1:0]  rresp_q,   rresp_d;

    // Register file
    logic [31:0] ctrl_q,      ctrl_d;
    logic [31:0] fb_base_q,   fb_base_d;
    logic [31:0] scratch_q,   scratch_d;
    logic [31:0] timing_q,    timing_d;
    logic        irq_stat_q,  irq_stat_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        irq_q,       irq_d;

    logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic        commit, wr_mapped;
    logic [31:0] wmask;
    logic [31:0] rd_word;
    logic [1:0]  rd_resp;

    // Protection bits and the byte offset inside a word carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign aw_hs     = S_AXI_AWVALID & awready_q;
    assign w_hs      = S_AXI_WVALID & wready_q;
    assign b_hs      = bvalid_q & S_AXI_BREADY;
    assign ar_hs     = S_AXI_ARVALID & arready_q;
    assign r_hs      = rvalid_q & S_AXI_RREADY;
    // Address and data are both latched: the write lands on the next edge.
    assign commit    = aw_held_q & w_held_q;
    assign wr_mapped = (awidx_q <= IDX_IRQ_STAT);

    // Expand the latched byte strobes into a bit mask.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_wmask
            assign wmask[gi*8 +: 8] = {8{wstrb_q[gi]}};
        end
    endgenerate

    // Write channel: independent AW/W capture, commit, and B response hold.
    always_comb begin
        awready_d = awready_q;
        wready_d  = wready_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awidx_d   = awidx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        if (aw_hs) begin
            awready_d = 1'b0;
            aw_held_d = 1'b1;
            awidx_d   = S_AXI_AWADDR[4:2];
        end
        if (w_hs) begin
            wready_d = 1'b0;
            w_held_d = 1'b1;
            wdata_d  = S_AXI_WDATA[31:0];
            wstrb_d  = S_AXI_WSTRB[3:0];
        end
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_mapped ? RESP_OKAY : RESP_SLVERR;
        end
        // Readies stay low until the response is taken, one write in flight.
        if (b_hs) begin
            bvalid_d  = 1'b0;
            awready_d = 1'b1;
            wready_d  = 1'b1;
        end
    end

    // Register file update: masked writes, W1C on IRQ_STAT, frame events.
    always_comb begin
        ctrl_d      = ctrl_q;
        fb_base_d   = fb_base_q;
        scratch_d   = scratch_q;
        timing_d    = timing_q;
        irq_stat_d  = irq_stat_q;
        frame_cnt_d = frame_cnt_q;
        if (commit) begin
            case (awidx_q)
                IDX_CTRL:     ctrl_d    = (ctrl_q    & ~wmask) | (wdata_q & wmask);
                IDX_FB_BASE:  fb_base_d = (fb_base_q & ~wmask) | (wdata_q & wmask);
                IDX_SCRATCH:  scratch_d = (scratch_q & ~wmask) | (wdata_q & wmask);
                IDX_TIMING:   timing_d  = (timing_q  & ~wmask) | (wdata_q & wmask);
                IDX_IRQ_STAT: if (wstrb_q[0] && wdata_q[0]) irq_stat_d = 1'b0;
                default:      ;
            endcase
        end
        // A frame event overrides a coincident clear so no event is lost.
        if (frame_done) begin
            irq_stat_d  = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
        irq_d = irq_stat_q & ctrl_q[1];
    end

    // Readback mux over the live registers.
    always_comb begin
        rd_word = 32'd0;
        rd_resp = RESP_OKAY;
        case (S_AXI_ARADDR[4:2])
            IDX_CTRL:     rd_word = ctrl_q;
            IDX_FB_BASE:  rd_word = fb_base_q;
            IDX_SCRATCH:  rd_word = scratch_q;
            IDX_TIMING:   rd_word = timing_q;
            IDX_STATUS:   rd_word = {frame_cnt_q, 15'd0, ctrl_q[0]};
            IDX_IRQ_STAT: rd_word = {31'd0, irq_stat_q};
            default:      rd_resp = RESP_SLVERR;
        endcase
    end

    // Read channel: capture on AR handshake, hold until RREADY.
    always_comb begin
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        if (ar_hs) begin
            arready_d = 1'b0;
            rvalid_d  = 1'b1;
            rdata_d   = rd_word;
            rresp_d   = rd_resp;
        end
        if (r_hs) begin
            rvalid_d  = 1'b0;
            arready_d = 1'b1;
        end
    end

    // State registers; reset aborts any transaction in flight.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            awready_q   <= 1'b1;
            wready_q    <= 1'b1;
            aw_held_q   <= 1'b0;
            w_held_q    <= 1'b0;
            awidx_q     <= 3'd0;
            wdata_q     <= 32'd0;
            wstrb_q     <= 4'd0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
            arready_q   <= 1'b1;
            rvalid_q    <= 1'b0;
            rdata_q     <= 32'd0;
            rresp_q     <= RESP_OKAY;
            ctrl_q      <= 32'd0;
            fb_base_q   <= 32'd0;
            scratch_q   <= 32'd0;
            timing_q    <= 32'd0;
            irq_stat_q  <= 1'b0;
            frame_cnt_q <= 16'd0;
            irq_q       <= 1'b0;
        end else begin
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            aw_held_q   <= aw_held_d;
            w_held_q    <= w_held_d;
            awidx_q     <= awidx_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            arready_q   <= arready_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
            ctrl_q      <= ctrl_d;
            fb_base_q   <= fb_base_d;
            scratch_q   <= scratch_d;
            timing_q    <= timing_d;
            irq_stat_q  <= irq_stat_d;
            frame_cnt_q <= frame_cnt_d;
            irq_q       <= irq_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign irq           = irq_q;

`ifdef AXI_DISP_SHADOW_EN
    logic        sh_enable_q;
    logic [31:0] sh_fb_base_q;
    logic [31:0] sh_timing_q;

    // Shadow copies reload only at frame boundaries so a frame never mixes settings.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            sh_enable_q  <= 1'b0;
            sh_fb_base_q <= 32'd0;
            sh_timing_q  <= 32'd0;
        end else if (frame_done) begin
            sh_enable_q  <= ctrl_q[0];
            sh_fb_base_q <= fb_base_q;
            sh_timing_q  <= timing_q;
        end
    end

    assign disp_enable = sh_enable_q;
    assign fb_base     = sh_fb_base_q;
    assign h_active    = sh_timing_q[15:0];
    assign v_active    = sh_timing_q[31:16];
`else
    assign disp_enable = ctrl_q[0];
    assign fb_base     = fb_base_q;
    assign h_active    = timing_q[15:0];
    assign v_active    = timing_q[31:16];
`endif

endmodule

// File: tb/tb_axi_display_regs.sv
// tb_axi_display_regs: directed bench for axi_display_regs with response
// scoreboards (expected B/R responses queued at issue, checked on arrival).
`timescale 1ns/1ps
module tb_axi_display_regs;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;
    logic [4:0]  araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b1;
    logic        frame_done = 1'b0;
    logic        disp_enable;
    logic [31:0] fb_base;
    logic [15:0] h_active;
    logic [15:0] v_active;
    logic        irq;

`ifdef AXI_DISP_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [1:0]  b_exp_q[$];
    logic [33:0] r_exp_q[$];
    int unsigned m_frames = 0;

    always #5 clk = ~clk;

    axi_display_regs dut (
        .ACLK          (clk),
        .ARESETN       (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .frame_done    (frame_done),
        .disp_enable   (disp_enable),
        .fb_base       (fb_base),
        .h_active      (h_active),
        .v_active      (v_active),
        .irq           (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive pending AW/W valids until each has handshaken.
    task automatic do_handshakes(input string tag);
        logic aw_go;
        logic w_go;
        int   cyc;
        cyc = 0;
        while ((awvalid || wvalid) && cyc < 20) begin
            aw_go = awvalid && awready;
            w_go  = wvalid && wready;
            tick();
            if (aw_go) awvalid = 1'b0;
            if (w_go)  wvalid  = 1'b0;
            cyc++;
        end
        check({tag, "_aw_w_pending"}, 32'(awvalid | wvalid), 32'd0);
        awvalid = 1'b0;
        wvalid  = 1'b0;
    endtask

    // Wait for BVALID, compare BRESP with the scoreboard, complete handshake.
    task automatic wait_b(input string tag);
        logic [1:0] exp;
        int         cyc;
        cyc = 0;
        while (!bvalid && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, "_bvalid"}, 32'(bvalid), 32'd1);
        exp = (b_exp_q.size() > 0) ? b_exp_q.pop_front() : 2'b11;
        if (bvalid) begin
            check({tag, "_bresp"}, 32'(bresp), 32'(exp));
            bready = 1'b1;
            tick();
        end
        $display("[TB] write %s bresp=%0b", tag, bresp);
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] exp_resp, input string tag);
        b_exp_q.push_back(exp_resp);
        awaddr  = a;
        wdata   = d;
        wstrb   = s;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        do_handshakes(tag);
        wait_b(tag);
    endtask

    task automatic axi_read(input logic [4:0] a, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp, input string tag);
        logic [33:0] exp;
        int          cyc;
        r_exp_q.push_back({exp_resp, exp_data});
        araddr  = a;
        arvalid = 1'b1;
        cyc = 0;
        while (!arready && cyc < 20) begin
            tick();
            cyc++;
        end
        tick();
        arvalid = 1'b0;
        cyc = 0;
        while (!rvalid && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
        exp = (r_exp_q.size() > 0) ? r_exp_q.pop_front() : 34'h3_FFFF_FFFF;
        check({tag, "_rdata"}, rdata, exp[31:0]);
        check({tag, "_rresp"}, 32'(rresp), 32'(exp[33:32]));
        $display("[TB] read 0x%02h rdata=0x%08h rresp=%0b", a, rdata, rresp);
        rready = 1'b1;
        tick();
    endtask

    task automatic pulse_frames(input int n);
        frame_done = 1'b1;
        repeat (n) tick();
        frame_done = 1'b0;
        m_frames += n;
    endtask

    initial begin
        #20_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("rst_awready", 32'(awready), 32'd1);
        check("rst_wready", 32'(wready), 32'd1);
        check("rst_arready", 32'(arready), 32'd1);
        check("rst_valids", 32'({bvalid, rvalid}), 32'd0);
        check("rst_resps", 32'({bresp, rresp}), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_side", 32'({disp_enable, irq}), 32'd0);
        check("rst_fb_base", fb_base, 32'd0);
        check("rst_timing", {v_active, h_active}, 32'd0);

        // Basic writes and readback
        axi_write(5'h00, 32'h1, 4'hF, 2'b00, "ctrl");
        axi_write(5'h04, 32'h2, 4'hF, 2'b00, "fb");
        axi_write(5'h08, 32'h3, 4'hF, 2'b00, "scratch");
        axi_write(5'h0C, 32'h4, 4'hF, 2'b00, "timing");
        axi_read(5'h00, 32'h1, 2'b00, "rd_ctrl");
        axi_read(5'h04, 32'h2, 2'b00, "rd_fb");
        axi_read(5'h08, 32'h3, 2'b00, "rd_scratch");
        axi_read(5'h0C, 32'h4, 2'b00, "rd_timing");
        check("side_enable", 32'(disp_enable), SHADOW ? 32'd0 : 32'd1);
        check("side_fb_base", fb_base, SHADOW ? 32'd0 : 32'd2);
        check("side_h_active", 32'(h_active), SHADOW ? 32'd0 : 32'd4);
        check("side_v_active", 32'(v_active), 32'd0);

        // W one cycle ahead of AW, partial strobes over zero
        axi_write(5'h04, 32'h0, 4'hF, 2'b00, "fb_clr");
        b_exp_q.push_back(2'b00);
        wdata  = 32'hAABBCCDD;
        wstrb  = 4'b0101;
        wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("wfirst_wready_low", 32'(wready), 32'd0);
        check("wfirst_awready_high", 32'(awready), 32'd1);
        awaddr  = 5'h04;
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("wfirst_no_early_b", 32'(bvalid), 32'd0);
        wait_b("wfirst");
        check("wfirst_single_b", 32'(bvalid), 32'd0);
        axi_read(5'h04, 32'h00BB00DD, 2'b00, "rd_wfirst");

        // BREADY held low: response and readies frozen, next AW refused
        bready = 1'b0;
        b_exp_q.push_back(2'b00);
        awaddr  = 5'h08;
        wdata   = 32'h5;
        wstrb   = 4'hF;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        tick();
        awaddr  = 5'h08;
        wdata   = 32'h6;
        awvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("stall_bvalid", 32'(bvalid), 32'd1);
            check("stall_bresp", 32'(bresp), 32'd0);
            check("stall_readies", 32'({awready, wready}), 32'd0);
            tick();
        end
        bready = 1'b1;
        wait_b("stall");
        check("stall_release_awready", 32'(awready), 32'd1);
        check("stall_release_wready", 32'(wready), 32'd1);
        b_exp_q.push_back(2'b00);
        wvalid = 1'b1;
        do_handshakes("second");
        wait_b("second");
        axi_read(5'h08, 32'h6, 2'b00, "rd_second");

        // Interrupt: enable, three frames, W1C, coincident set/clear
        axi_write(5'h00, 32'h2, 4'hF, 2'b00, "ctrl_irq_en");
        for (int i = 0; i < 3; i++) pulse_frames(1);
        tick();
        check("irq_set", 32'(irq), 32'd1);
        axi_read(5'h10, {m_frames[15:0], 16'h0000}, 2'b00, "rd_status3");
        axi_write(5'h14, 32'h1, 4'hF, 2'b00, "w1c");
        tick();
        check("irq_cleared", 32'(irq), 32'd0);
        axi_read(5'h14, 32'h0, 2'b00, "rd_irqstat_clr");
        b_exp_q.push_back(2'b00);
        awaddr  = 5'h14;
        wdata   = 32'h1;
        wstrb   = 4'hF;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        tick();
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        m_frames++;
        wait_b("w1c_vs_set");
        axi_read(5'h14, 32'h1, 2'b00, "rd_set_wins");
        tick();
        check("irq_set_wins", 32'(irq), 32'd1);

        // Read on the same edge as a write commit returns the old value
        b_exp_q.push_back(2'b00);
        awaddr  = 5'h0C;
        wdata   = 32'h0010_0020;
        wstrb   = 4'hF;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        r_exp_q.push_back({2'b00, 32'h4});
        araddr  = 5'h0C;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        check("coll_rvalid", 32'(rvalid), 32'd1);
        check("coll_rdata_old", rdata, r_exp_q.pop_front()[31:0]);
        check("coll_bvalid", 32'(bvalid), 32'd1);
        check("coll_bresp", 32'(bresp), 32'(b_exp_q.pop_front()));
        tick();
        axi_read(5'h0C, 32'h0010_0020, 2'b00, "rd_timing_new");
        check("side_h_active2", 32'(h_active), SHADOW ? 32'h4 : 32'h20);
        check("side_v_active2", 32'(v_active), SHADOW ? 32'h0 : 32'h10);

        // Unmapped addresses
        axi_read(5'h18, 32'h0, 2'b10, "rd_unmapped");
        axi_write(5'h1C, 32'hFFFF_FFFF, 4'hF, 2'b10, "wr_unmapped");
        axi_read(5'h00, 32'h2, 2'b00, "rd_ctrl_keep");
        axi_read(5'h04, 32'h00BB00DD, 2'b00, "rd_fb_keep");
        axi_read(5'h08, 32'h6, 2'b00, "rd_scratch_keep");
        axi_read(5'h0C, 32'h0010_0020, 2'b00, "rd_timing_keep");

        // Frame counter reaches 0xFFFF, then wraps
        pulse_frames(65535 - int'(m_frames));
        axi_read(5'h10, 32'hFFFF_0000, 2'b00, "rd_status_max");
        pulse_frames(2);
        axi_read(5'h10, {m_frames[15:0], 16'h0000}, 2'b00, "rd_status_wrap");

        // Reset asserted while a read response is pending
        rready  = 1'b0;
        araddr  = 5'h08;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        check("midrd_rvalid", 32'(rvalid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrd_rvalid_abort", 32'(rvalid), 32'd0);
        check("midrd_rdata", rdata, 32'd0);
        check("midrd_readies", 32'({awready, wready, arready}), 32'h7);
        check("midrd_irq", 32'(irq), 32'd0);
        check("midrd_fb_base", fb_base, 32'd0);
        tick();
        rst_n    = 1'b1;
        rready   = 1'b1;
        m_frames = 0;
        tick();
        axi_read(5'h00, 32'h0, 2'b00, "rst_rd_ctrl");
        axi_read(5'h04, 32'h0, 2'b00, "rst_rd_fb");
        axi_read(5'h08, 32'h0, 2'b00, "rst_rd_scratch");
        axi_read(5'h0C, 32'h0, 2'b00, "rst_rd_timing");
        axi_read(5'h10, 32'h0, 2'b00, "rst_rd_status");
        axi_read(5'h14, 32'h0, 2'b00, "rst_rd_irqstat");

        // Side output timing relative to frame_done
        axi_write(5'h04, 32'h0000_1234, 4'hF, 2'b00, "fb_shadow");
        tick();
        check("fb_before_frame", fb_base, SHADOW ? 32'h0 : 32'h1234);
        pulse_frames(1);
        tick();
        check("fb_after_frame", fb_base, 32'h1234);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
